// File: rtl/srl32_fifo_ctrl_if.sv
// Handshake bundle for srl32_fifo_ctrl: write side (S_*), read side (M_*) and optional status.
// Status signals exist only when SRL32_FIFO_STATUS_EN is defined.
interface srl32_fifo_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             S_VALID;
  logic             S_READY;
  logic [WIDTH-1:0] S_DATA;
  logic             M_VALID;
  logic             M_READY;
  logic [WIDTH-1:0] M_DATA;
`ifdef SRL32_FIFO_STATUS_EN
  logic [5:0]       LEVEL;
  logic             ALMOST_FULL;
`endif

  // FIFO side
  modport slave (
    input  S_VALID, S_DATA, M_READY,
`ifdef SRL32_FIFO_STATUS_EN
    output LEVEL, ALMOST_FULL,
`endif
    output S_READY, M_VALID, M_DATA
  );

  // Producer/consumer side
  modport master (
    output S_VALID, S_DATA, M_READY,
`ifdef SRL32_FIFO_STATUS_EN
    input  LEVEL, ALMOST_FULL,
`endif
    input  S_READY, M_VALID, M_DATA
  );
endinterface

// File: rtl/srl32_fifo_ctrl.sv
// 33-entry FIFO: 32-deep SRL32E-style shift storage per bit plus a registered output stage.
// Latency: 2 cycles write-to-read; backpressure: S_READY low only when SRL holds 32, independent of M_READY.
// Optional LEVEL/ALMOST_FULL status under macro SRL32_FIFO_STATUS_EN.
module srl32_fifo_ctrl #(
  parameter int WIDTH     = 8,
  parameter int AFULL_LVL = 28
) (
  input  logic              CLK,
  input  logic              RST_N,
  srl32_fifo_ctrl_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > 64 || AFULL_LVL < 1 || AFULL_LVL > 33) begin : g_param_check
    $error("srl32_fifo_ctrl: parameter out of range");
  end

  logic [5:0]       r_cnt;
  logic             r_m_valid;
  logic [WIDTH-1:0] r_m_data;

  logic             w_s_ready;
  logic             w_push;
  logic             w_load;
  logic [4:0]       w_addr;
  logic [WIDTH-1:0] w_q;
  logic [5:0]       w_cnt_nxt;
  logic             w_m_valid_nxt;

  assign w_s_ready = (r_cnt != 6'd32);
  assign w_push    = bus.S_VALID & w_s_ready;
  assign w_load    = (r_cnt != 6'd0) & (~r_m_valid | bus.M_READY);
  // Head sits at cnt-1; at cnt=0 this wraps to 31 and is never loaded.
  assign w_addr    = 5'(r_cnt - 6'd1);

  // One SRL32E-equivalent per bit: shared CE and tap address, no reset on contents.
  for (genvar b = 0; b < WIDTH; b++) begin : g_srl
    logic [31:0] r_sh;
    always_ff @(posedge CLK) begin
      if (w_push)
        r_sh <= {r_sh[30:0], bus.S_DATA[b]};
    end
    assign w_q[b] = r_sh[w_addr];
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_load)
      w_cnt_nxt = r_cnt + 6'd1;
    else if (w_load && !w_push)
      w_cnt_nxt = r_cnt - 6'd1;
  end

  always_comb begin
    w_m_valid_nxt = r_m_valid;
    if (w_load)
      w_m_valid_nxt = 1'b1;
    else if (r_m_valid && bus.M_READY)
      w_m_valid_nxt = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= 6'd0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_m_valid <= w_m_valid_nxt;
      if (w_load)
        r_m_data <= w_q;
    end
  end

  assign bus.S_READY = w_s_ready;
  assign bus.M_VALID = r_m_valid;
  assign bus.M_DATA  = r_m_data;

`ifdef SRL32_FIFO_STATUS_EN
  logic       r_almost_full;
  logic [5:0] w_level_nxt;

  // Registered from next-state occupancy so it lines up with the combinational LEVEL.
  assign w_level_nxt = 6'(w_cnt_nxt + {5'd0, w_m_valid_nxt});

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      r_almost_full <= 1'b0;
    else
      r_almost_full <= (w_level_nxt >= 6'(AFULL_LVL));
  end

  assign bus.LEVEL       = 6'(r_cnt + {5'd0, r_m_valid});
  assign bus.ALMOST_FULL = r_almost_full;
`endif

endmodule

// File: tb/tb_srl32_fifo_ctrl.sv
// Scoreboard bench for srl32_fifo_ctrl: inputs driven and outputs sampled on the falling edge.
// Status checks are compiled only when SRL32_FIFO_STATUS_EN is defined.
module tb_srl32_fifo_ctrl;
  localparam int WIDTH     = 8;
  localparam int AFULL_LVL = 28;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int   total = 0;
  int   bad = 0;
  logic [7:0] q[$];

  srl32_fifo_ctrl_if #(.WIDTH(WIDTH)) bus ();

  srl32_fifo_ctrl #(.WIDTH(WIDTH), .AFULL_LVL(AFULL_LVL)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL watchdog: sim time expired before completion");
    $fatal(1, "watchdog");
  end

  // One clock: drive at the falling edge, report what the next rising edge will do.
  task automatic step(input logic sv, input logic [7:0] d, input logic mr,
                      output logic pu, output logic po, output logic [7:0] od,
                      output logic sr);
    @(negedge CLK);
    sr = bus.S_READY;
    od = bus.M_DATA;
    po = bus.M_VALID & mr;
    pu = sv & sr;
    bus.S_VALID = sv;
    bus.S_DATA  = d;
    bus.M_READY = mr;
    @(posedge CLK);
  endtask

  task automatic test_reset;
    bus.S_VALID = 1'b0; bus.S_DATA = 8'h00; bus.M_READY = 1'b0;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    total++; if (bus.M_VALID !== 1'b0) begin bad++; $display("FAIL reset_mvalid got=%b exp=0", bus.M_VALID); end
    total++; if (bus.M_DATA !== 8'h00) begin bad++; $display("FAIL reset_mdata got=%h exp=00", bus.M_DATA); end
    total++; if (bus.S_READY !== 1'b1) begin bad++; $display("FAIL reset_sready got=%b exp=1", bus.S_READY); end
`ifdef SRL32_FIFO_STATUS_EN
    total++; if (bus.LEVEL !== 6'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", bus.LEVEL); end
    total++; if (bus.ALMOST_FULL !== 1'b0) begin bad++; $display("FAIL reset_afull got=%b exp=0", bus.ALMOST_FULL); end
`endif
    RST_N = 1'b1;
  endtask

  task automatic test_single;
    logic pu, po, sr; logic [7:0] od, exp;
    step(1'b1, 8'hA5, 1'b0, pu, po, od, sr);
    total++; if (pu !== 1'b1) begin bad++; $display("FAIL single_push_accept got=%b exp=1", pu); end
    if (pu) q.push_back(8'hA5);
    step(1'b0, 8'h00, 1'b0, pu, po, od, sr);
    total++; if (bus.M_VALID !== 1'b0) begin bad++; $display("FAIL single_mvalid_early got=%b exp=0", bus.M_VALID); end
    @(negedge CLK);
    total++; if (bus.M_VALID !== 1'b1) begin bad++; $display("FAIL single_mvalid got=%b exp=1", bus.M_VALID); end
    total++; if (bus.M_DATA !== 8'hA5) begin bad++; $display("FAIL single_mdata got=%h exp=a5", bus.M_DATA); end
`ifdef SRL32_FIFO_STATUS_EN
    total++; if (bus.LEVEL !== 6'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", bus.LEVEL); end
`endif
    for (int c = 0; c < 10 && (q.size() != 0 || bus.M_VALID); c++) begin
      step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
      if (po) begin
        total++;
        exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
        if (od !== exp) begin bad++; $display("FAIL single_pop got=%h exp=%h", od, exp); end
      end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL single_drain left=%0d exp=0", q.size()); end
  endtask

  task automatic test_fill;
    logic pu, po, sr; logic [7:0] od, exp; int npop;
    for (int i = 0; i <= 32; i++) begin
      step(1'b1, 8'(i), 1'b0, pu, po, od, sr);
      total++; if (pu !== 1'b1) begin bad++; $display("FAIL fill_accept idx=%0d got=%b exp=1", i, pu); end
      if (pu) q.push_back(8'(i));
    end
    step(1'b1, 8'h55, 1'b0, pu, po, od, sr);
    total++; if (sr !== 1'b0) begin bad++; $display("FAIL fill_full_sready got=%b exp=0", sr); end
    if (pu) q.push_back(8'h55);
    npop = 0;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
      if (po) begin
        total++; npop++;
        exp = q.pop_front();
        if (od !== exp) begin bad++; $display("FAIL fill_order got=%h exp=%h", od, exp); end
      end
    end
    total++; if (npop != 33) begin bad++; $display("FAIL fill_popcount got=%0d exp=33", npop); end
    @(negedge CLK);
    total++; if (bus.M_VALID !== 1'b0) begin bad++; $display("FAIL fill_empty_mvalid got=%b exp=0", bus.M_VALID); end
    bus.M_READY = 1'b0;
  endtask

  task automatic test_stream;
    logic pu, po, sr; logic [7:0] od, exp; int npop; int first;
    npop = 0; first = -1;
    for (int c = 0; c < 100; c++) begin
      total++; if (q.size() > 2) begin bad++; $display("FAIL stream_occupancy got=%0d exp<=2", q.size()); end
      step(1'b1, 8'(c + 8'h40), 1'b1, pu, po, od, sr);
      if (po) begin
        total++; npop++;
        if (first < 0) first = c;
        exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
        if (od !== exp) begin bad++; $display("FAIL stream_data got=%h exp=%h", od, exp); end
      end
      if (pu) q.push_back(8'(c + 8'h40));
    end
    total++; if (first != 2) begin bad++; $display("FAIL stream_latency got=%0d exp=2", first); end
    total++; if (npop != 98) begin bad++; $display("FAIL stream_rate got=%0d exp=98", npop); end
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
      if (po) begin
        total++;
        exp = q.pop_front();
        if (od !== exp) begin bad++; $display("FAIL stream_drain got=%h exp=%h", od, exp); end
      end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL stream_left got=%0d exp=0", q.size()); end
  endtask

  task automatic test_random;
    logic pu, po, sr, sv, mr; logic [7:0] od, exp, d; int npush;
    npush = 0;
    for (int c = 0; c < 60000 && (npush < 10000 || q.size() != 0); c++) begin
      sv = (npush < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      mr = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      step(sv, d, mr, pu, po, od, sr);
      total++; if (sr !== (q.size() != 33)) begin bad++; $display("FAIL rand_sready got=%b held=%0d", sr, q.size()); end
      if (po) begin
        total++;
        exp = (q.size() != 0) ? q.pop_front() : 8'hxx;
        if (od !== exp) begin bad++; $display("FAIL rand_data got=%h exp=%h", od, exp); end
      end
      if (pu) begin q.push_back(d); npush++; end
    end
    total++; if (npush != 10000) begin bad++; $display("FAIL rand_pushcount got=%0d exp=10000", npush); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rand_left got=%0d exp=0", q.size()); end
  endtask

  task automatic test_async_reset;
    logic pu, po, sr; logic [7:0] od, exp; int npop;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(8'h90 + i), 1'b0, pu, po, od, sr);
    end
    bus.S_VALID = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    total++; if (bus.M_VALID !== 1'b0) begin bad++; $display("FAIL arst_mvalid got=%b exp=0", bus.M_VALID); end
    total++; if (bus.S_READY !== 1'b1) begin bad++; $display("FAIL arst_sready got=%b exp=1", bus.S_READY); end
    total++; if (bus.M_DATA !== 8'h00) begin bad++; $display("FAIL arst_mdata got=%h exp=00", bus.M_DATA); end
    q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST_N = 1'b1;
    for (int c = 0; c < 3; c++) step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
    @(negedge CLK);
    total++; if (bus.M_VALID !== 1'b0) begin bad++; $display("FAIL arst_stale got=%b exp=0", bus.M_VALID); end
    step(1'b1, 8'h3C, 1'b1, pu, po, od, sr);
    if (pu) q.push_back(8'h3C);
    step(1'b1, 8'h3D, 1'b1, pu, po, od, sr);
    if (pu) q.push_back(8'h3D);
    npop = 0;
    for (int c = 0; c < 10 && q.size() != 0; c++) begin
      step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
      if (po) begin
        total++; npop++;
        exp = q.pop_front();
        if (od !== exp) begin bad++; $display("FAIL arst_first got=%h exp=%h", od, exp); end
      end
    end
    total++; if (npop != 2) begin bad++; $display("FAIL arst_popcount got=%0d exp=2", npop); end
  endtask

`ifdef SRL32_FIFO_STATUS_EN
  task automatic test_status;
    logic pu, po, sr; logic [7:0] od, exp;
    for (int i = 1; i <= AFULL_LVL; i++) begin
      step(1'b1, 8'(i), 1'b0, pu, po, od, sr);
      if (pu) q.push_back(8'(i));
      @(negedge CLK);
      total++; if (bus.LEVEL !== 6'(q.size())) begin bad++; $display("FAIL status_level got=%0d exp=%0d", bus.LEVEL, q.size()); end
      total++; if (bus.ALMOST_FULL !== (i >= AFULL_LVL)) begin bad++; $display("FAIL status_afull lvl=%0d got=%b", i, bus.ALMOST_FULL); end
    end
    step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
    if (po) begin
      total++;
      exp = q.pop_front();
      if (od !== exp) begin bad++; $display("FAIL status_pop got=%h exp=%h", od, exp); end
    end
    bus.M_READY = 1'b0;
    @(negedge CLK);
    total++; if (bus.LEVEL !== 6'(AFULL_LVL - 1)) begin bad++; $display("FAIL status_level_drop got=%0d exp=%0d", bus.LEVEL, AFULL_LVL - 1); end
    total++; if (bus.ALMOST_FULL !== 1'b0) begin bad++; $display("FAIL status_afull_drop got=%b exp=0", bus.ALMOST_FULL); end
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      step(1'b0, 8'h00, 1'b1, pu, po, od, sr);
      if (po) begin
        total++;
        exp = q.pop_front();
        if (od !== exp) begin bad++; $display("FAIL status_drain got=%h exp=%h", od, exp); end
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fill;
    test_stream;
    test_random;
    test_async_reset;
`ifdef SRL32_FIFO_STATUS_EN
    test_status;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
